// File: rtl/mips_pkg.sv
// Shared MIPS-32 definitions: opcode/funct encodings, ALU operation enum,
// and the datapath control-strobe bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic reg_read;
    logic mem_read;
    logic mem_write;
    logic to_reg;
    logic rt_rd;
  } ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: operation plus operands to 32-bit result.
// Shifts apply to operand b by shamt, so lui and branch offsets reuse ALU_SLL.
module alu_core
  import mips_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_control_datamem.sv
// Single-cycle MIPS execute/memory stage: decode, ALU, branch decision and
// word-addressed data memory. Define DATAMEM_TRACE_EN to print stores and reset clears.
module alu_control_datamem
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        reg_write,
  output logic        reg_read,
  output logic        mem_read,
  output logic        mem_write,
  output logic        to_reg,
  output logic        rt_rd,
  output logic        branch,
  output logic [31:0] alu_result,
  output logic [31:0] mem_read_data
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] se_imm;
  logic [31:0] ze_imm;
  ctrl_t       ctrl;
  alu_op_e     alu_op;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;

  assign se_imm = {{16{immediate[15]}}, immediate};
  assign ze_imm = {16'b0, immediate};

  always_comb begin
    ctrl      = '0;
    alu_op    = ALU_ZERO;
    alu_b     = rt_data;
    alu_shamt = immediate[10:6];
    branch    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl = '{reg_write: 1'b1, reg_read: 1'b1, rt_rd: 1'b1, default: 1'b0};
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_JR:           ctrl   = '{reg_read: 1'b1, default: 1'b0};
          default:         ctrl   = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl   = '{reg_write: 1'b1, reg_read: 1'b1, default: 1'b0};
        alu_op = ALU_ADD;
        alu_b  = se_imm;
      end
      OP_SLTI, OP_SLTIU: begin
        ctrl   = '{reg_write: 1'b1, reg_read: 1'b1, default: 1'b0};
        alu_op = (opcode == OP_SLTI) ? ALU_SLT : ALU_SLTU;
        alu_b  = se_imm;
      end
      OP_ANDI, OP_ORI: begin
        ctrl   = '{reg_write: 1'b1, reg_read: 1'b1, default: 1'b0};
        alu_op = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        alu_b  = ze_imm;
      end
      OP_LUI: begin
        ctrl      = '{reg_write: 1'b1, reg_read: 1'b1, default: 1'b0};
        alu_op    = ALU_SLL;
        alu_b     = ze_imm;
        alu_shamt = 5'd16;
      end
      OP_LW: begin
        ctrl   = '{reg_write: 1'b1, reg_read: 1'b1, mem_read: 1'b1, to_reg: 1'b1,
                   default: 1'b0};
        alu_op = ALU_ADD;
        alu_b  = se_imm;
      end
      OP_SW: begin
        ctrl   = '{reg_read: 1'b1, mem_write: 1'b1, default: 1'b0};
        alu_op = ALU_ADD;
        alu_b  = se_imm;
      end
      OP_BEQ, OP_BNE: begin
        // Result is the byte offset; the equality test is done here, not in the ALU.
        ctrl      = '{reg_read: 1'b1, default: 1'b0};
        alu_op    = ALU_SLL;
        alu_b     = se_imm;
        alu_shamt = 5'd2;
        branch    = (opcode == OP_BEQ) ? (rs_data == rt_data) : (rs_data != rt_data);
      end
      OP_J:    ctrl = '0;
      OP_JAL:  ctrl = '{reg_write: 1'b1, default: 1'b0};
      default: ctrl = '0;
    endcase
  end

  assign reg_write = ctrl.reg_write;
  assign reg_read  = ctrl.reg_read;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign to_reg    = ctrl.to_reg;
  assign rt_rd     = ctrl.rt_rd;

  alu_core u_alu_core (
    .op     (alu_op),
    .a      (rs_data),
    .b      (alu_b),
    .shamt  (alu_shamt),
    .result (alu_result)
  );

  // Low two address bits dropped; upper bits dropped too, so addresses wrap.
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] word_idx;

  assign word_idx      = alu_result[AW+1:2];
  assign mem_read_data = rst_n ? mem[word_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
`ifdef DATAMEM_TRACE_EN
      $display("datamem: reset clear");
`endif
    end else if (mem_write) begin
      mem[word_idx] <= rt_data;
`ifdef DATAMEM_TRACE_EN
      $display("datamem: store word %0d = %h", word_idx, rt_data);
`endif
    end
  end

endmodule

// File: tb/tb_alu_control_datamem.sv
// Directed bench for alu_control_datamem: decode strobes, ALU results, branch,
// and data memory store/load/reset behaviour, checked with immediate assertions.
module tb_alu_control_datamem;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        reg_write, reg_read, mem_read, mem_write, to_reg, rt_rd, branch;
  logic [31:0] alu_result;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  alu_control_datamem #(.MEM_WORDS(256)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .immediate     (immediate),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .reg_write     (reg_write),
    .reg_read      (reg_read),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .to_reg        (to_reg),
    .rt_rd         (rt_rd),
    .branch        (branch),
    .alu_result    (alu_result),
    .mem_read_data (mem_read_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {reg_write, reg_read, mem_read, mem_write, to_reg, rt_rd}
  function automatic logic [5:0] strobes();
    return {reg_write, reg_read, mem_read, mem_write, to_reg, rt_rd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: apply an instruction just after a falling edge, settle before sampling.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    opcode    = op;
    funct     = fn;
    immediate = imm;
    rs_data   = rs;
    rt_data   = rt;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'h3F; funct = 6'h00; immediate = '0; rs_data = '0; rt_data = '0;

    drive(6'h23, 6'h00, 16'h0000, 32'h0, 32'h0);
    check("reset_read_zero", mem_read_data, 32'h0);
    check("reset_comb_follow", {26'b0, strobes()}, 32'b111010);
    @(negedge clk);
    rst_n = 1'b1;

    drive(6'h00, 6'h20, 16'h0000, 32'd5, 32'hFFFF_FFFF);
    check("add_result", alu_result, 32'd4);
    check("add_strobes", {26'b0, strobes()}, 32'b110001);
    drive(6'h00, 6'h2A, 16'h0000, 32'hFFFF_FFFF, 32'd1);
    check("slt_result", alu_result, 32'd1);
    drive(6'h00, 6'h2B, 16'h0000, 32'hFFFF_FFFF, 32'd1);
    check("sltu_result", alu_result, 32'd0);
    drive(6'h00, 6'h00, 16'h0100, 32'h0, 32'd1);
    check("sll_result", alu_result, 32'h10);
    drive(6'h00, 6'h02, 16'h07C0, 32'h0, 32'h8000_0000);
    check("srl_result", alu_result, 32'h1);
    drive(6'h00, 6'h22, 16'h0000, 32'd3, 32'd5);
    check("sub_result", alu_result, 32'hFFFF_FFFE);
    drive(6'h00, 6'h27, 16'h0000, 32'h0, 32'hF0F0_F0F0);
    check("nor_result", alu_result, 32'h0F0F_0F0F);
    drive(6'h00, 6'h08, 16'h0000, 32'd9, 32'd9);
    check("jr_result", alu_result, 32'h0);
    check("jr_strobes", {26'b0, strobes()}, 32'b010000);
    drive(6'h00, 6'h3F, 16'h0000, 32'd9, 32'd9);
    check("bad_funct_strobes", {26'b0, strobes()}, 32'b000000);
    check("bad_funct_result", alu_result, 32'h0);

    drive(6'h08, 6'h00, 16'hFFFF, 32'h10, 32'h0);
    check("addi_result", alu_result, 32'hF);
    check("addi_strobes", {26'b0, strobes()}, 32'b110000);
    drive(6'h0C, 6'h00, 16'h8000, 32'hFFFF_FFFF, 32'h0);
    check("andi_zext", alu_result, 32'h8000);
    drive(6'h0D, 6'h00, 16'h8001, 32'h0, 32'h0);
    check("ori_zext", alu_result, 32'h8001);
    drive(6'h0A, 6'h00, 16'hFFFF, 32'hFFFF_FFFE, 32'h0);
    check("slti_result", alu_result, 32'h1);
    drive(6'h0B, 6'h00, 16'hFFFF, 32'd5, 32'h0);
    check("sltiu_result", alu_result, 32'h1);
    drive(6'h0F, 6'h00, 16'h1234, 32'hFFFF_FFFF, 32'h0);
    check("lui_result", alu_result, 32'h1234_0000);

    drive(6'h04, 6'h00, 16'hFFFE, 32'd7, 32'd7);
    check("beq_branch", {31'b0, branch}, 32'h1);
    check("beq_offset", alu_result, 32'hFFFF_FFF8);
    check("beq_strobes", {26'b0, strobes()}, 32'b010000);
    drive(6'h05, 6'h00, 16'hFFFE, 32'd7, 32'd7);
    check("bne_branch", {31'b0, branch}, 32'h0);
    drive(6'h05, 6'h00, 16'h0003, 32'd7, 32'd8);
    check("bne_taken", {31'b0, branch}, 32'h1);
    check("bne_offset", alu_result, 32'hC);
    drive(6'h03, 6'h00, 16'h1234, 32'd7, 32'd8);
    check("jal_result", alu_result, 32'h0);
    check("jal_strobes", {26'b0, strobes()}, 32'b100000);
    check("jal_branch", {31'b0, branch}, 32'h0);
    drive(6'h02, 6'h00, 16'h1234, 32'd7, 32'd8);
    check("j_strobes", {26'b0, strobes()}, 32'b000000);
    drive(6'h3F, 6'h20, 16'h1234, 32'd7, 32'd7);
    check("bad_op_strobes", {26'b0, strobes()}, 32'b000000);
    check("bad_op_result", alu_result, 32'h0);

    // Store then load; read-during-write shows old word before the edge.
    drive(6'h2B, 6'h00, 16'h0008, 32'h100, 32'hDEAD_BEEF);
    check("sw_addr", alu_result, 32'h108);
    check("sw_strobes", {26'b0, strobes()}, 32'b010100);
    check("sw_old_word", mem_read_data, 32'h0);
    @(posedge clk); #1;
    check("sw_new_word", mem_read_data, 32'hDEAD_BEEF);
    drive(6'h23, 6'h00, 16'h0008, 32'h100, 32'h0);
    check("lw_data", mem_read_data, 32'hDEAD_BEEF);
    check("lw_strobes", {26'b0, strobes()}, 32'b111010);
    drive(6'h23, 6'h00, 16'h0008, 32'h500, 32'h0);
    check("lw_wrap", mem_read_data, 32'hDEAD_BEEF);
    drive(6'h23, 6'h00, 16'h0000, 32'h10B, 32'h0);
    check("lw_misaligned", mem_read_data, 32'hDEAD_BEEF);
    drive(6'h23, 6'h00, 16'h000C, 32'h100, 32'h0);
    check("lw_neighbour", mem_read_data, 32'h0);

    // Reset mid-operation
    drive(6'h2B, 6'h00, 16'h0000, 32'h40, 32'h1234);
    @(posedge clk); #1;
    drive(6'h23, 6'h00, 16'h0000, 32'h40, 32'h0);
    check("lw_pre_reset", mem_read_data, 32'h1234);
    rst_n = 1'b0;
    #1;
    check("reset_clears_now", mem_read_data, 32'h0);
    rst_n = 1'b1;
    #1;
    check("after_pulse_read", mem_read_data, 32'h0);
    drive(6'h23, 6'h00, 16'h0008, 32'h100, 32'h0);
    check("reset_clears_other", mem_read_data, 32'h0);
    drive(6'h2B, 6'h00, 16'h0000, 32'h40, 32'h5555);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_store_read0", mem_read_data, 32'h0);
    check("reset_sw_strobe", {31'b0, mem_write}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("blocked_store", mem_read_data, 32'h0);
    @(posedge clk); #1;
    check("first_store_after", mem_read_data, 32'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
